// File: rtl/bf16_pkg.sv
// Shared definitions for the bfloat16 operation scheduler: opcode encodings,
// the quiet-NaN result returned for the reserved opcode, the scheduler FSM
// state type and the tag that travels alongside each operation.
package bf16_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } bf16_op_e;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    // One tag per accepted operation: valid, requester id, reserved-opcode flag.
    typedef struct packed {
        logic valid;
        logic id;
        logic rsv;
    } sched_tag_t;

endpackage

// File: rtl/bf16_rr_arb.sv
// Two-input arbiter for the scheduler. Grants are combinational and only
// given while en is high; last holds the id of the most recent grant and
// resets to 1 so requester 0 wins the first contention.
// Build option: BF16_SCHED_FIXED_PRIO_EN selects fixed priority
// (requester 0 always wins) instead of round-robin.
module bf16_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       last
);

    // Pick at most one requester this cycle.
    always_comb begin
        grant = 2'b00;
        if (en) begin
`ifdef BF16_SCHED_FIXED_PRIO_EN
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
`else
            if (req == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
`endif
        end
    end

    // Remember who was granted last so contention alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (grant != 2'b00) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/bf16_op_scheduler.sv
// Shares one bfloat16 ALU between two requesters. Accepted operations are
// registered into the issue stage, a tag follows each one through an
// ALU_LAT-deep pipe, and the response (ALU result or qNaN for the reserved
// opcode) is registered out as a one-cycle pulse in issue order.
// flush moves the FSM to DRAIN (no new accepts) and then DONE once nothing
// is left in flight.
// Build option: BF16_SCHED_FIXED_PRIO_EN (fixed priority arbitration, see
// bf16_rr_arb).
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is the combinational grant, never
// depends on anything but req_valid and registered state, and is low outside
// RUN. Responses have no backpressure.
import bf16_pkg::*;

module bf16_op_scheduler #(
    parameter int ALU_LAT = 3,
    parameter int NREQ    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 alu_valid,
    output logic [1:0]           alu_op,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    input  logic [15:0]          alu_result,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [15:0]          rsp_data,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [1:0]           dbg_state,
    output logic [3:0]           dbg_inflight,
    output logic                 dbg_last
);

    sched_state_e state_q, state_d;
    logic [1:0]   grant;
    logic         accept;
    logic         acc_id;
    logic [1:0]   acc_op;
    logic [15:0]  acc_a, acc_b;
    sched_tag_t   iss_tag;
    sched_tag_t   tag_q [ALU_LAT];
    logic         pipe_empty;
    logic [3:0]   inflight_q;

    bf16_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (state_q == ST_RUN),
        .grant (grant),
        .last  (dbg_last)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign acc_id    = grant[1];
    assign acc_op    = acc_id ? req_op[3:2]  : req_op[1:0];
    assign acc_a     = acc_id ? req_a[31:16] : req_a[15:0];
    assign acc_b     = acc_id ? req_b[31:16] : req_b[15:0];

    // Issue stage: the reserved opcode takes a tag slot but never reaches the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_tag   <= '0;
            alu_valid <= 1'b0;
            alu_op    <= 2'b00;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
        end else if (accept) begin
            iss_tag.valid <= 1'b1;
            iss_tag.id    <= acc_id;
            iss_tag.rsv   <= (acc_op == OP_RSV);
            alu_valid     <= (acc_op != OP_RSV);
            alu_op        <= acc_op;
            alu_a         <= acc_a;
            alu_b         <= acc_b;
        end else begin
            iss_tag   <= '0;
            alu_valid <= 1'b0;
        end
    end

    // Tag pipe: the last stage lines up with alu_result for the same op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ALU_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= iss_tag;
            for (int k = 1; k < ALU_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Response stage: register the tag and pick ALU result or qNaN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 16'h0000;
        end else begin
            rsp_valid <= tag_q[ALU_LAT-1].valid;
            rsp_id    <= tag_q[ALU_LAT-1].valid & tag_q[ALU_LAT-1].id;
            if (!tag_q[ALU_LAT-1].valid) begin
                rsp_data <= 16'h0000;
            end else if (tag_q[ALU_LAT-1].rsv) begin
                rsp_data <= BF16_QNAN;
            end else begin
                rsp_data <= alu_result;
            end
        end
    end

    // In-flight count: accepts minus responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 4'd0;
        end else begin
            unique case ({accept, rsp_valid})
                2'b10:   inflight_q <= inflight_q + 4'd1;
                2'b01:   inflight_q <= inflight_q - 4'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Nothing left between the issue register and the last tag stage.
    always_comb begin
        pipe_empty = !iss_tag.valid;
        for (int k = 0; k < ALU_LAT; k++) begin
            if (tag_q[k].valid) begin
                pipe_empty = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an accept in the same cycle as flush still completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (flush)      state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
            ST_DONE:  if (!flush)     state_d = ST_RUN;
            default:                  state_d = ST_RUN;
        endcase
    end

    assign flush_done   = (state_q == ST_DONE);
    assign dbg_state    = state_q;
    assign dbg_inflight = inflight_q;

endmodule
